uart_xcvr_param: RTL and testbench
==================================

// Module: uart_xcvr_param
// PURPOSE
//  Parametrised full-duplex UART: transmitter and receiver in one block, with configurable data width,
//  baud divisor and stop bits. Adds framing-error and overrun detection and glitch-rejecting start detect.
//  Sits between the command/telemetry logic and the RF/serial pins of the quadcopter controller.
// PARAMETERS
//  DATA_BITS  8     data bits per frame, legal 5..9, sent LSB first
//  BAUD_DIV   2604  clk cycles per bit (50 MHz / 19200); legal >= 8; BAUD_DIV/2 is the mid-bit point
//  STOP_BITS  1     stop bits sent by TX (1 or 2); RX always checks only the first stop bit
// PORTS
//  clk       in   1          system clock; all logic is on the posedge
//  rst       in   1          one clock; reset is synchronous and active-high
//  trmt      in   1          start a TX frame with tx_data (sampled on posedge)
//  tx_data   in   DATA_BITS  byte to transmit
//  TX        out  1          serial out, idle high
//  tx_busy   out  1          frame in progress
//  tx_done   out  1          sticky: frame complete; cleared by next accepted trmt
//  RX        in   1          serial in, asynchronous
//  clr_rdy   in   1          clear rdy and overrun
//  rx_data   out  DATA_BITS  last received data
//  rdy       out  1          sticky: rx_data holds a new frame
//  frm_err   out  1          stop bit sampled low on the last frame; updated on every frame completion
//  overrun   out  1          sticky: a frame completed while rdy was already 1
//  par_err   out  1          only when UART_PARITY_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: TX=1, tx_busy=0, tx_done=0, rx_data=0, rdy=0, frm_err=0, overrun=0, par_err=0.
//    The RX synchroniser flops reset to 1. Reset mid-frame aborts both FSMs immediately. TX=1 on the next clock.
//  - Baud counters are $clog2(BAUD_DIV+1) bits wide. Bit counters are $clog2(DATA_BITS+4) bits wide.
//  - TX FSM IDLE->XMIT: on trmt in IDLE, load shift reg {stop(s),[parity],data,0}. Clear tx_done.
//    tx_busy=1 and TX=0 (start bit) from the next clock.
//  - TX shifting: shift every BAUD_DIV clocks. Frame length is (1+DATA_BITS+P+STOP_BITS)*BAUD_DIV clocks, with P=0/1.
//  - TX completion: after the last stop-bit period, go to IDLE, set tx_busy=0 and tx_done=1 in the same cycle.
//    trmt while tx_busy=1 is ignored. trmt in the same cycle tx_busy falls is also ignored.
//    trmt is accepted again one clock later.
//  - RX front end: 2-flop synchroniser, then a falling-edge detect. RX FSM states IDLE->START->RECV.
//  - RX START: on a falling edge, wait BAUD_DIV/2 clocks. If RX is high at that point it is a glitch: return to IDLE.
//    No flags change.
//  - RX RECV: sample every BAUD_DIV clocks at mid-bit for DATA_BITS data bits, then [parity], then 1 stop bit.
//  - RX completion, one clock after the stop-bit sample:
//    - load rx_data and set rdy=1;
//    - frm_err = ~stop;
//    - overrun is set if rdy was 1, and rx_data is overwritten with the newest frame;
//    - return to IDLE. A new start bit is accepted from the next clock.
//  - clr_rdy clears rdy and overrun. If clr_rdy coincides with RX completion, completion wins:
//    rdy=1 and overrun unchanged (no overrun set).
//  - TX and RX are fully independent. Simultaneous TX and RX activity is legal.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   - TX inserts an even-parity bit (^data) after the data bits.
//   - RX samples the parity bit. par_err is set to (received parity != ^rx_data) at completion, updated every frame.
//   - The par_err port exists.
//  UART_PARITY_EN undefined:
//   - No parity bit; frame is 1+DATA_BITS+STOP_BITS bits.
//   - The par_err port is absent.
// TESTING (bench: BAUD_DIV=16, TX looped to RX unless noted)
//  1. DATA_BITS=8: trmt with tx_data=8'hE4 -> TX low 1 clk later.
//     tx_done=1 after 160 clks. rdy=1 with rx_data=8'hE4, frm_err=0.
//  2. Send 8'h00 then 8'hFF back to back. clr_rdy after each -> both received. overrun=0.
//  3. Send 8'hA5, no clr_rdy, then send 8'h3C -> rx_data=8'h3C, rdy=1, overrun=1.
//     Then clr_rdy -> rdy=0, overrun=0.
//  4. Drive RX (unlooped) low for 5 clks, then high -> rdy stays 0 and the FSM returns to IDLE.
//     A frame with stop bit forced low -> rdy=1, frm_err=1.
//  5. Assert rst mid-frame (bit 4 of 8'h5A) -> TX=1, tx_busy=0, rdy=0 next clk.
//     A fresh 8'h5A afterwards is received correctly.
//  6. UART_PARITY_EN, DATA_BITS=7: send 7'h55 -> parity bit=0, par_err=0.
//     Flip the parity bit on the line -> par_err=1.

Source files
------------

// File: rtl/uart_xcvr_param.sv
// ---------------------------------------------------------------------------
// uart_xcvr_param
//
// Full-duplex UART with a transmitter and a receiver in one block. Data
// width, baud divisor and stop-bit count are parameters. The receiver flags
// framing errors and overruns. A glitch filter re-checks the start bit at
// mid-bit before the receiver commits to a frame.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : TX appends an even-parity bit (^data) after the data bits.
//               RX checks that bit and reports the result on par_err.
//   undefined : no parity bit is sent or expected, and there is no par_err port.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9), sent LSB first
//   BAUD_DIV   clk cycles per bit (>= 8); BAUD_DIV/2 is the mid-bit point
//   STOP_BITS  stop bits sent by TX (1 or 2); RX checks only the first one
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous, active-high reset
//   trmt     in   start a TX frame with tx_data (ignored while busy)
//   tx_data  in   word to transmit
//   TX       out  serial out, idle high
//   tx_busy  out  TX frame in progress
//   tx_done  out  sticky: frame complete; cleared by next accepted trmt
//   RX       in   serial in, asynchronous to clk
//   clr_rdy  in   clear rdy and overrun
//   rx_data  out  last received word
//   rdy      out  sticky: rx_data holds a new frame
//   frm_err  out  stop bit of the last frame was sampled low
//   overrun  out  sticky: a frame completed while rdy was still set
//   par_err  out  (UART_PARITY_EN only) parity of the last frame was wrong
// ---------------------------------------------------------------------------
module uart_xcvr_param #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frm_err,
    output logic                 overrun
`ifdef UART_PARITY_EN
    ,
    output logic                 par_err
`endif
);

`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Full TX frame: start + data + [parity] + stop(s).
    localparam int TX_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    // RX captures everything after the start bit up to the first stop bit.
    localparam int RX_BITS = DATA_BITS + PAR_BITS + 1;

    localparam int BAUD_W = $clog2(BAUD_DIV + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 4);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  TX_LAST   = BIT_W'(TX_BITS - 1);
    localparam logic [BIT_W-1:0]  RX_LAST   = BIT_W'(RX_BITS - 1);

    // =======================================================================
    // Transmitter
    // =======================================================================
    typedef enum logic {
        TX_IDLE,
        TX_XMIT
    } tx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]    tx_baud_q,  tx_baud_d;
    logic [BIT_W-1:0]     tx_bit_q,   tx_bit_d;
    logic [TX_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                 tx_done_q,  tx_done_d;
    logic [TX_BITS-1:0]   tx_frame;

`ifdef UART_PARITY_EN
    assign tx_frame = {{STOP_BITS{1'b1}}, ^tx_data, tx_data, 1'b0};
`else
    assign tx_frame = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
`endif

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path
        // through the case can leave one unassigned and infer a latch.
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done_d  = tx_done_q;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_shift_d = tx_frame;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_done_d  = 1'b0;
                    tx_state_d = TX_XMIT;
                end
            end
            TX_XMIT: begin
                // trmt is not looked at here, so a request during a frame
                // (including the cycle the frame ends) is dropped.
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    // Shifting in ones leaves the register all-ones when the
                    // frame ends, so TX idles high without a separate mux.
                    tx_shift_d = {1'b1, tx_shift_q[TX_BITS-1:1]};
                    if (tx_bit_q == TX_LAST) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_busy = (tx_state_q == TX_XMIT);
    assign tx_done = tx_done_q;

    // =======================================================================
    // Receiver
    // =======================================================================
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_RECV,
        RX_DONE
    } rx_state_e;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_fall;

    rx_state_e            rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]    rx_baud_q,  rx_baud_d;
    logic [BIT_W-1:0]     rx_bit_q,   rx_bit_d;
    logic [RX_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rdy_q,      rdy_d;
    logic                 frm_err_q,  frm_err_d;
    logic                 overrun_q,  overrun_d;
`ifdef UART_PARITY_EN
    logic                 par_err_q,  par_err_d;
`endif

    // NOTE: RX is asynchronous; two flops settle metastability before any
    // logic looks at it. They reset high (idle line) so that leaving reset
    // cannot look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = frm_err_q;
        overrun_d  = overrun_q;
`ifdef UART_PARITY_EN
        par_err_d  = par_err_q;
`endif

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit after the edge: a pulse that
                // has already ended is noise, not a start bit.
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_RECV;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_RECV: begin
                // Aligned to mid-start, so each full period lands mid-bit.
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[RX_BITS-1:1]};
                    if (rx_bit_q == RX_LAST) begin
                        rx_state_d = RX_DONE;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_DONE: begin
                // Completion takes priority over a coincident clr_rdy: the
                // new frame is flagged, and a clear in the same cycle blocks
                // a new overrun.
                rx_data_d  = rx_shift_q[DATA_BITS-1:0];
                rdy_d      = 1'b1;
                frm_err_d  = ~rx_shift_q[RX_BITS-1];
                overrun_d  = clr_rdy ? overrun_q : (overrun_q | rdy_q);
`ifdef UART_PARITY_EN
                par_err_d  = rx_shift_q[DATA_BITS] ^ (^rx_shift_q[DATA_BITS-1:0]);
`endif
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
            overrun_q  <= overrun_d;
`ifdef UART_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign overrun = overrun_q;
`ifdef UART_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_uart_xcvr_param.sv
// ---------------------------------------------------------------------------
// tb_uart_xcvr_param
//
// Bench for uart_xcvr_param with DATA_BITS=8, BAUD_DIV=16, STOP_BITS=1.
// TX is normally looped back to RX. For the glitch and framing cases, RX is
// instead driven directly from the bench (loop_en=0).
// ---------------------------------------------------------------------------
module tb_uart_xcvr_param;

    localparam int DB = 8;
    localparam int BD = 16;
    localparam int SB = 1;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_BITS = 1 + DB + PB + SB;
    localparam int FRAME_CLKS = FRAME_BITS * BD;

    logic          clk = 1'b0;
    logic          rst;
    logic          trmt;
    logic [DB-1:0] tx_data;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;
    logic          rx;
    logic          clr_rdy;
    logic [DB-1:0] rx_data;
    logic          rdy;
    logic          frm_err;
    logic          overrun;
`ifdef UART_PARITY_EN
    logic          par_err;
`endif

    logic loop_en;
    logic rx_drv;
    assign rx = loop_en ? tx : rx_drv;

    int total = 0;
    int bad   = 0;

    // Scoreboard for the receive flags.
    logic          m_rdy;
    logic          m_ovr;
    logic [DB-1:0] m_data;

    uart_xcvr_param #(
        .DATA_BITS(DB),
        .BAUD_DIV (BD),
        .STOP_BITS(SB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .trmt   (trmt),
        .tx_data(tx_data),
        .TX     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .RX     (rx),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .frm_err(frm_err),
        .overrun(overrun)
`ifdef UART_PARITY_EN
        ,
        .par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level during bit k of a frame carrying d.
    function automatic logic model_bit(input logic [DB-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (PB == 1 && k == DB + 1) return ^d;
        return 1'b1;
    endfunction

    // Send d over the loopback. Optionally clear rdy in the accept cycle,
    // optionally pulse a bogus trmt mid-frame. Checks mid-bit TX levels and
    // frame length. Returns at the negedge where tx_done is first seen high.
    task automatic send_frame(input logic [DB-1:0] d, input bit clr, input bit bogus);
        int n;
        int bogus_at;
        tx_data = d;
        trmt    = 1'b1;
        clr_rdy = clr;
        @(negedge clk);
        trmt     = 1'b0;
        clr_rdy  = 1'b0;
        tx_data  = ~d;
        bogus_at = $urandom_range(20, FRAME_CLKS - 20);
        n = 0;
        while (!tx_done && n < FRAME_CLKS + 20) begin
            if (n % BD == BD / 2) check("tx_bit", tx, model_bit(d, n / BD));
            trmt = (bogus && n == bogus_at);
            @(negedge clk);
            n++;
        end
        trmt = 1'b0;
        check("tx_done_seen", tx_done, 1'b1);
        check("frame_len", n, FRAME_CLKS);
    endtask

    task automatic drive_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_flip);
        rx_drv = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_drv = d[i];
            repeat (BD) @(negedge clk);
        end
        if (PB == 1) begin
            rx_drv = (^d) ^ par_flip;
            repeat (BD) @(negedge clk);
        end
        rx_drv = stop_v;
        repeat (BD) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    typedef struct {
        logic [DB-1:0] data;
        bit            clr;
        logic [DB-1:0] exp_data;
        logic          exp_rdy;
        logic          exp_ovr;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   n;

        vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[3] = '{8'h7E, 1'b0, 8'h7E, 1'b1, 1'b1};
        vecs[4] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[5] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1};

        rst     = 1'b1;
        trmt    = 1'b0;
        tx_data = '0;
        clr_rdy = 1'b0;
        loop_en = 1'b1;
        rx_drv  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rdy", rdy, 1'b0);
        check("rst_frm_err", frm_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
`ifdef UART_PARITY_EN
        check("rst_par_err", par_err, 1'b0);
`endif
        repeat (4) @(negedge clk);

        // Single frame, exact timing, plus trmt in the cycle busy falls.
        tx_data = 8'hE4;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        check("t1_start_tx", tx, 1'b0);
        check("t1_start_busy", tx_busy, 1'b1);
        for (n = 0; n < FRAME_CLKS; n++) begin
            if (n % BD == BD / 2) check("t1_tx_bit", tx, model_bit(8'hE4, n / BD));
            if (n == FRAME_CLKS - 1) begin
                check("t1_done_early", tx_done, 1'b0);
                check("t1_busy_late", tx_busy, 1'b1);
                trmt    = 1'b1;
                tx_data = 8'h11;
            end
            @(negedge clk);
        end
        check("t1_done", tx_done, 1'b1);
        check("t1_busy_fall", tx_busy, 1'b0);
        trmt = 1'b0;
        @(negedge clk);
        check("t1_trmt_at_fall_ignored", tx_busy, 1'b0);
        check("t1_idle_tx", tx, 1'b1);
        check("t1_rdy", rdy, 1'b1);
        check("t1_rx_data", rx_data, 8'hE4);
        check("t1_frm_err", frm_err, 1'b0);
        check("t1_overrun", overrun, 1'b0);

        // Table: back-to-back frames, with and without clearing rdy.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].clr, 1'b0);
            check("tbl_rx_data", rx_data, vecs[i].exp_data);
            check("tbl_rdy", rdy, vecs[i].exp_rdy);
            check("tbl_overrun", overrun, vecs[i].exp_ovr);
            check("tbl_frm_err", frm_err, 1'b0);
        end
        pulse_clr();
        check("clr_rdy", rdy, 1'b0);
        check("clr_overrun", overrun, 1'b0);

        // Completion wins over a coincident clr_rdy.
        clr_rdy = 1'b1;
        tx_data = 8'h69;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        n = 0;
        while (!rdy && n < FRAME_CLKS + 20) begin
            @(negedge clk);
            n++;
        end
        clr_rdy = 1'b0;
        @(negedge clk);
        check("cw_rdy", rdy, 1'b1);
        check("cw_rx_data", rx_data, 8'h69);
        check("cw_overrun", overrun, 1'b0);
        n = 0;
        while (!tx_done && n < FRAME_CLKS + 20) begin
            @(negedge clk);
            n++;
        end
        check("cw_tx_done", tx_done, 1'b1);
        repeat (4) @(negedge clk);

        // Glitch rejection and framing error with RX driven directly.
        loop_en = 1'b0;
        pulse_clr();
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_frm_err", frm_err, 1'b0);
        drive_frame(8'h96, 1'b0, 1'b0);
        check("ferr_rdy", rdy, 1'b1);
        check("ferr_rx_data", rx_data, 8'h96);
        check("ferr_frm_err", frm_err, 1'b1);
        pulse_clr();
        drive_frame(8'h2D, 1'b1, 1'b0);
        check("good_rdy", rdy, 1'b1);
        check("good_rx_data", rx_data, 8'h2D);
        check("good_frm_err", frm_err, 1'b0);
`ifdef UART_PARITY_EN
        check("par_ok", par_err, 1'b0);
        pulse_clr();
        drive_frame(8'h55, 1'b1, 1'b1);
        check("par_bad_rdy", rdy, 1'b1);
        check("par_bad", par_err, 1'b1);
        pulse_clr();
        drive_frame(8'h55, 1'b1, 1'b0);
        check("par_recover", par_err, 1'b0);
`endif
        loop_en = 1'b1;
        repeat (4) @(negedge clk);

        // Reset in the middle of data bit 4; rdy is still set from above.
        tx_data = 8'h5A;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (5 * BD + BD / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_rdy", rdy, 1'b0);
        check("mid_rst_done", tx_done, 1'b0);
        repeat (2 * BD) @(negedge clk);
        check("post_rst_rdy", rdy, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("post_rst_rx_data", rx_data, 8'h5A);
        check("post_rst_rdy2", rdy, 1'b1);
        check("post_rst_frm_err", frm_err, 1'b0);
        check("post_rst_overrun", overrun, 1'b0);

        // Random frames against the scoreboard, with stray trmt pulses.
        m_rdy  = 1'b1;
        m_ovr  = 1'b0;
        m_data = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            logic [DB-1:0] d;
            bit            c;
            bit            b;
            d = DB'($urandom);
            c = bit'($urandom_range(0, 1));
            b = bit'($urandom_range(0, 1));
            if (c) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            m_ovr  = m_ovr | m_rdy;
            m_rdy  = 1'b1;
            m_data = d;
            send_frame(d, c, b);
            check("rnd_rx_data", rx_data, m_data);
            check("rnd_rdy", rdy, m_rdy);
            check("rnd_overrun", overrun, m_ovr);
            check("rnd_frm_err", frm_err, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
